// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//
// Purpose:
//   Up/down counter over the range 0..limit with three boundary behaviours
//   (wrap, saturate, one-shot), a load path that clamps to limit, a one-cycle
//   terminal-count pulse, a sticky wrap flag and a gated count output.
//
// Configuration macro:
//   PUDC_PRESCALER_EN - when defined, adds a PRESCALE_W-bit prescaler and the
//                       'prescale' port; a step then happens only once every
//                       (prescale+1) enabled cycles. When undefined, every
//                       enabled cycle is a step candidate and no prescaler
//                       logic or port exists.
//
// Parameters:
//   WIDTH       counter width in bits (2..32)
//   PRESCALE_W  prescaler width in bits (used only with PUDC_PRESCALER_EN)
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous active-high reset
//   cnt_en     in   count enable
//   load       in   load strobe, sampled every cycle
//   load_val   in   load data (clamped to limit)
//   dir        in   1 = up, 0 = down
//   mode       in   00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   limit      in   upper bound of the count range
//   clr_ovf    in   clears ovf_sticky (a simultaneous wrap wins)
//   out_en     in   enables count_out
//   prescale   in   divide value (PUDC_PRESCALER_EN only)
//   count_out  out  count when out_en=1 and reset=0, else zero
//   tc         out  registered one-cycle terminal-count pulse
//   ovf_sticky out  sticky wrap flag
//   running    out  counter armed
// -----------------------------------------------------------------------------
module param_updown_counter #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cnt_en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  clr_ovf,
    input  logic                  out_en,
`ifdef PUDC_PRESCALER_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0]      count_out,
    output logic                  tc,
    output logic                  ovf_sticky,
    output logic                  running
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);

    // Parameter sanity marker: an out-of-range configuration elaborates this
    // empty block, which makes the illegal setting easy to spot in a netlist.
    generate
        if ((WIDTH < 2) || (WIDTH > 32) || (PRESCALE_W < 1)) begin : g_illegal_params
        end
    endgenerate

    // Clamp a value into 0..lim.
    function automatic logic [WIDTH-1:0] clamp_to_limit(
        input logic [WIDTH-1:0] val,
        input logic [WIDTH-1:0] lim
    );
        if (val > lim) begin
            return lim;
        end else begin
            return val;
        end
    endfunction

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic             r_running;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;
    logic             w_ovf_nxt;
    logic             w_running_nxt;
    logic             w_tick;
    logic             w_step;
    logic             w_boundary;

`ifdef PUDC_PRESCALER_EN
    localparam logic [PRESCALE_W-1:0] PRE_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PRE_ONE  = PRESCALE_W'(1'b1);

    logic [PRESCALE_W-1:0] r_pre;
    logic                  w_pre_hit;

    assign w_pre_hit = (r_pre == prescale);
    assign w_tick    = w_pre_hit;

    // Prescaler: advances only on armed, enabled cycles; wraps to 0 on a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre <= PRE_ZERO;
        end else if (load) begin
            r_pre <= PRE_ZERO;
        end else if (cnt_en && r_running) begin
            if (w_pre_hit) begin
                r_pre <= PRE_ZERO;
            end else begin
                r_pre <= r_pre + PRE_ONE;
            end
        end else begin
            r_pre <= r_pre;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    assign w_step = cnt_en && r_running && !load && w_tick;

    // ">= limit" (not "==") so a count left above a lowered limit is still a
    // boundary going up and gets clamped instead of climbing further.
    assign w_boundary = dir ? (r_count >= limit) : (r_count == CNT_ZERO);

    // Next-state: load beats step beats hold; tc is only ever a one-cycle echo
    // of a boundary step.
    always_comb begin
        w_count_nxt   = r_count;
        w_tc_nxt      = 1'b0;
        w_ovf_nxt     = clr_ovf ? 1'b0 : r_ovf;
        w_running_nxt = r_running;
        if (load) begin
            w_count_nxt   = clamp_to_limit(load_val, limit);
            w_running_nxt = 1'b1;
        end else if (w_step) begin
            if (!w_boundary) begin
                if (dir) begin
                    w_count_nxt = r_count + CNT_ONE;
                end else begin
                    w_count_nxt = r_count - CNT_ONE;
                end
            end else begin
                w_tc_nxt = 1'b1;
                case (mode)
                    2'b01: begin
                        w_count_nxt = clamp_to_limit(r_count, limit);
                    end
                    2'b10: begin
                        w_count_nxt   = clamp_to_limit(r_count, limit);
                        w_running_nxt = 1'b0;
                    end
                    default: begin
                        // Wrap (mode 00 and 11); the set overrides clr_ovf.
                        w_count_nxt = dir ? CNT_ZERO : limit;
                        w_ovf_nxt   = 1'b1;
                    end
                endcase
            end
        end else begin
            w_count_nxt = r_count;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= CNT_ZERO;
            r_tc      <= 1'b0;
            r_ovf     <= 1'b0;
            r_running <= 1'b1;
        end else begin
            r_count   <= w_count_nxt;
            r_tc      <= w_tc_nxt;
            r_ovf     <= w_ovf_nxt;
            r_running <= w_running_nxt;
        end
    end

    // Gating with reset keeps count_out at zero for the whole reset window,
    // including the part of the first reset cycle before the edge.
    assign count_out  = (out_en && !reset) ? r_count : CNT_ZERO;
    assign tc         = r_tc;
    assign ovf_sticky = r_ovf;
    assign running    = r_running;

endmodule

// File: tb/tb_param_updown_counter.sv
module tb_param_updown_counter;

    localparam int WIDTH      = 8;
    localparam int PRESCALE_W = 4;

    logic                  clk;
    logic                  reset;
    logic                  cnt_en;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic                  dir;
    logic [1:0]            mode;
    logic [WIDTH-1:0]      limit;
    logic                  clr_ovf;
    logic                  out_en;
`ifdef PUDC_PRESCALER_EN
    logic [PRESCALE_W-1:0] prescale;
`endif
    logic [WIDTH-1:0]      count_out;
    logic                  tc;
    logic                  ovf_sticky;
    logic                  running;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (plain integers)
    int m_count;
    bit m_tc;
    bit m_ovf;
    bit m_run;
    int m_pre;

    param_updown_counter #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cnt_en     (cnt_en),
        .load       (load),
        .load_val   (load_val),
        .dir        (dir),
        .mode       (mode),
        .limit      (limit),
        .clr_ovf    (clr_ovf),
        .out_en     (out_en),
`ifdef PUDC_PRESCALER_EN
        .prescale   (prescale),
`endif
        .count_out  (count_out),
        .tc         (tc),
        .ovf_sticky (ovf_sticky),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by the rules of one clock edge, then let the DUT take
    // the same edge; returns 1 time unit after the edge.
    task automatic clock_cycle();
        int  c;
        int  lim;
        bit  tick;
        bit  tc_n;
        bit  ovf_n;
        c   = m_count;
        lim = int'(limit);
        if (reset) begin
            c = 0; tc_n = 1'b0; ovf_n = 1'b0; m_run = 1'b1; m_pre = 0;
        end else if (load) begin
            c     = (int'(load_val) < lim) ? int'(load_val) : lim;
            m_run = 1'b1;
            tc_n  = 1'b0;
            ovf_n = clr_ovf ? 1'b0 : m_ovf;
            m_pre = 0;
        end else begin
            tick = 1'b1;
`ifdef PUDC_PRESCALER_EN
            if (cnt_en && m_run) begin
                tick  = (m_pre == int'(prescale));
                m_pre = tick ? 0 : m_pre + 1;
            end
`endif
            tc_n  = 1'b0;
            ovf_n = clr_ovf ? 1'b0 : m_ovf;
            if (cnt_en && m_run && tick) begin
                if (dir && c < lim) begin
                    c = c + 1;
                end else if (!dir && c > 0) begin
                    c = c - 1;
                end else begin
                    tc_n = 1'b1;
                    if (mode == 2'd1 || mode == 2'd2) begin
                        if (c > lim) c = lim;
                        if (mode == 2'd2) m_run = 1'b0;
                    end else begin
                        c     = dir ? 0 : lim;
                        ovf_n = 1'b1;
                    end
                end
            end
        end
        m_count = c;
        m_tc    = tc_n;
        m_ovf   = ovf_n;
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        reset = 1'b0; cnt_en = 1'b0; load = 1'b0; load_val = 8'd0;
        dir = 1'b1; mode = 2'b00; limit = 8'd9; clr_ovf = 1'b0; out_en = 1'b1;
`ifdef PUDC_PRESCALER_EN
        prescale = 4'd0;
`endif
    endtask

    task automatic do_reset();
        set_defaults();
        reset = 1'b1;
        clock_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_defaults();
        cnt_en = 1'b1; load = 1'b1; load_val = 8'd7; clr_ovf = 1'b0;
        reset = 1'b1;
        clock_cycle();
        n_checks++;
        if (count_out !== 8'd0) begin n_errors++; $display("FAIL reset_count got=%0d exp=0", count_out); end
        n_checks++;
        if (tc !== 1'b0) begin n_errors++; $display("FAIL reset_tc got=%b exp=0", tc); end
        n_checks++;
        if (ovf_sticky !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_sticky); end
        n_checks++;
        if (running !== 1'b1) begin n_errors++; $display("FAIL reset_running got=%b exp=1", running); end
        reset = 1'b0;
    endtask

    task automatic test_wrap_up();
        logic [WIDTH-1:0] exp_cnt;
        do_reset();
        limit = 8'd9; mode = 2'b00; dir = 1'b1; cnt_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            clock_cycle();
            exp_cnt = (k == 10) ? 8'd0 : 8'(k);
            n_checks++;
            if (count_out !== exp_cnt) begin n_errors++; $display("FAIL wrap_count step=%0d got=%0d exp=%0d", k, count_out, exp_cnt); end
            n_checks++;
            if (tc !== (k == 10)) begin n_errors++; $display("FAIL wrap_tc step=%0d got=%b exp=%b", k, tc, (k == 10)); end
        end
        n_checks++;
        if (ovf_sticky !== 1'b1) begin n_errors++; $display("FAIL wrap_ovf got=%b exp=1", ovf_sticky); end
        cnt_en = 1'b0;
        clock_cycle();
        n_checks++;
        if (tc !== 1'b0) begin n_errors++; $display("FAIL wrap_tc_width got=%b exp=0", tc); end
    endtask

    task automatic test_saturate_down();
        logic [WIDTH-1:0] exp_cnt [4] = '{8'd1, 8'd0, 8'd0, 8'd0};
        logic             exp_tc  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        mode = 2'b01; dir = 1'b0; limit = 8'd9; load_val = 8'd2; load = 1'b1;
        clock_cycle();
        load = 1'b0; cnt_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            clock_cycle();
            n_checks++;
            if (count_out !== exp_cnt[k]) begin n_errors++; $display("FAIL sat_count step=%0d got=%0d exp=%0d", k + 1, count_out, exp_cnt[k]); end
            n_checks++;
            if (tc !== exp_tc[k]) begin n_errors++; $display("FAIL sat_tc step=%0d got=%b exp=%b", k + 1, tc, exp_tc[k]); end
            n_checks++;
            if (ovf_sticky !== 1'b0) begin n_errors++; $display("FAIL sat_ovf step=%0d got=%b exp=0", k + 1, ovf_sticky); end
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        mode = 2'b10; dir = 1'b1; limit = 8'd3; load_val = 8'd0; load = 1'b1;
        clock_cycle();
        load = 1'b0; cnt_en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            clock_cycle();
            n_checks++;
            if (count_out !== 8'(k)) begin n_errors++; $display("FAIL oneshot_count step=%0d got=%0d exp=%0d", k, count_out, k); end
        end
        clock_cycle();
        n_checks++;
        if (running !== 1'b0) begin n_errors++; $display("FAIL oneshot_running got=%b exp=0", running); end
        n_checks++;
        if (tc !== 1'b1) begin n_errors++; $display("FAIL oneshot_tc got=%b exp=1", tc); end
        for (int k = 0; k < 3; k++) begin
            clock_cycle();
            n_checks++;
            if (count_out !== 8'd3 || tc !== 1'b0) begin n_errors++; $display("FAIL oneshot_hold got=%0d/%b exp=3/0", count_out, tc); end
        end
        load_val = 8'd1; load = 1'b1;
        clock_cycle();
        n_checks++;
        if (count_out !== 8'd1 || running !== 1'b1) begin n_errors++; $display("FAIL oneshot_rearm got=%0d/%b exp=1/1", count_out, running); end
        load = 1'b0;
        clock_cycle();
        n_checks++;
        if (count_out !== 8'd2) begin n_errors++; $display("FAIL oneshot_after_rearm got=%0d exp=2", count_out); end
    endtask

    task automatic test_load_priority();
        do_reset();
        mode = 2'b00; dir = 1'b1; limit = 8'd50; load_val = 8'd200;
        load = 1'b1; cnt_en = 1'b1;
        clock_cycle();
        n_checks++;
        if (count_out !== 8'd50) begin n_errors++; $display("FAIL load_clamp got=%0d exp=50", count_out); end
        n_checks++;
        if (tc !== 1'b0) begin n_errors++; $display("FAIL load_tc got=%b exp=0", tc); end
        load = 1'b0; clr_ovf = 1'b1;
        clock_cycle();
        n_checks++;
        if (ovf_sticky !== 1'b1 || count_out !== 8'd0) begin n_errors++; $display("FAIL clr_vs_wrap got=%b/%0d exp=1/0", ovf_sticky, count_out); end
        cnt_en = 1'b0;
        clock_cycle();
        n_checks++;
        if (ovf_sticky !== 1'b0) begin n_errors++; $display("FAIL clr_ovf got=%b exp=0", ovf_sticky); end
        clr_ovf = 1'b0;
    endtask

    task automatic test_out_en();
        do_reset();
        limit = 8'd255; mode = 2'b00; dir = 1'b1; out_en = 1'b0; cnt_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            clock_cycle();
            n_checks++;
            if (count_out !== 8'd0) begin n_errors++; $display("FAIL outen_gated step=%0d got=%0d exp=0", k + 1, count_out); end
        end
        cnt_en = 1'b0; out_en = 1'b1;
        #1;
        n_checks++;
        if (count_out !== 8'd5) begin n_errors++; $display("FAIL outen_show got=%0d exp=5", count_out); end
        cnt_en = 1'b1; reset = 1'b1;
        #1;
        n_checks++;
        if (count_out !== 8'd0) begin n_errors++; $display("FAIL reset_held_out got=%0d exp=0", count_out); end
        clock_cycle();
        n_checks++;
        if (count_out !== 8'd0) begin n_errors++; $display("FAIL reset_mid_count got=%0d exp=0", count_out); end
        reset = 1'b0;
        clock_cycle();
        n_checks++;
        if (count_out !== 8'd1) begin n_errors++; $display("FAIL after_reset_step got=%0d exp=1", count_out); end
    endtask

`ifdef PUDC_PRESCALER_EN
    task automatic test_prescaler();
        do_reset();
        prescale = 4'd3; limit = 8'd255; cnt_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            clock_cycle();
            n_checks++;
            if (count_out !== 8'(k / 4)) begin n_errors++; $display("FAIL presc_count cyc=%0d got=%0d exp=%0d", k, count_out, k / 4); end
        end
        do_reset();
        prescale = 4'd3; limit = 8'd255; cnt_en = 1'b1;
        clock_cycle();
        clock_cycle();
        load_val = 8'd10; load = 1'b1;
        clock_cycle();
        load = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            clock_cycle();
            n_checks++;
            if (count_out !== ((k == 4) ? 8'd11 : 8'd10)) begin n_errors++; $display("FAIL presc_restart cyc=%0d got=%0d exp=%0d", k, count_out, (k == 4) ? 11 : 10); end
        end
    endtask
`endif

    task automatic test_random();
        logic [WIDTH-1:0] exp_cnt;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            reset    = ($urandom_range(0, 63) == 0);
            load     = ($urandom_range(0, 7) == 0);
            cnt_en   = ($urandom_range(0, 3) != 0);
            clr_ovf  = ($urandom_range(0, 7) == 0);
            dir      = 1'($urandom_range(0, 1));
            mode     = 2'($urandom_range(0, 3));
            out_en   = ($urandom_range(0, 5) != 0);
            load_val = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) begin
                limit = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
            end
`ifdef PUDC_PRESCALER_EN
            prescale = 4'($urandom_range(0, 2));
`endif
            clock_cycle();
            exp_cnt = (out_en && !reset) ? 8'(m_count) : 8'd0;
            n_checks++;
            if (count_out !== exp_cnt || tc !== m_tc || ovf_sticky !== m_ovf || running !== m_run) begin
                n_errors++;
                $display("FAIL random cyc=%0d got cnt=%0d tc=%b ovf=%b run=%b exp cnt=%0d tc=%b ovf=%b run=%b",
                         k, count_out, tc, ovf_sticky, running, exp_cnt, m_tc, m_ovf, m_run);
            end
        end
    endtask

    initial begin
        m_count = 0; m_tc = 1'b0; m_ovf = 1'b0; m_run = 1'b1; m_pre = 0;
        set_defaults();
        test_reset();
        test_wrap_up();
        test_saturate_down();
        test_oneshot();
        test_load_priority();
        test_out_en();
`ifdef PUDC_PRESCALER_EN
        test_prescaler();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
